mem_access_ctrl: RTL and testbench

//  Downstream of the sLC3 control FSM: turns its active-low Mem_OE/Mem_WE strobes plus MAR/MDR into

---
 rtl/mem_access_ctrl.sv | 77 +++++++
 tb/tb_mem_access_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns sLC3 FSM memory strobes into cycle-exact SRAM pin sequences plus one I/O word
module mem_access_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter logic [15:0] IO_ADDR = 16'hFFFF,
  parameter logic [DATA_W-1:0] HEX_RST = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       MAR,
  input  logic [DATA_W-1:0] MDR,
  input  logic              Mem_CE,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [DATA_W-1:0] Switches,
  input  logic [DATA_W-1:0] SRAM_DQ_in,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [DATA_W-1:0] SRAM_DQ_out,
  output logic              SRAM_DQ_oe,
  output logic [DATA_W-1:0] Data_to_CPU,
  output logic [DATA_W-1:0] Hex_val,
  output logic              Bus_err
);
  localparam logic [2:0] IDLE = 3'd0, RD1 = 3'd1, RD2 = 3'd2, WR_SETUP = 3'd3,
                         WR_PULSE = 3'd4, WR_HOLD = 3'd5, ERR = 3'd6;
  logic [2:0] state, nxt;
  logic [DATA_W-1:0] sw_meta, sw_sync, rd_latch, data_q;
  logic seen, is_io;
  assign is_io = MAR == IO_ADDR;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:     nxt = (!Mem_OE && !Mem_WE) ? ERR : !Mem_OE ? RD1 : !Mem_WE ? WR_SETUP : IDLE;
      RD1:      nxt = !Mem_OE ? RD2 : IDLE;
      WR_SETUP: nxt = !Mem_WE ? WR_PULSE : IDLE;
      WR_PULSE: nxt = WR_HOLD;
      ERR:      nxt = (Mem_OE && Mem_WE) ? IDLE : ERR;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      sw_meta <= '0;
      sw_sync <= '0;
      rd_latch <= '0;
      data_q <= '0;
      Hex_val <= HEX_RST;
      Bus_err <= 1'b0;
      seen <= 1'b0;
    end else begin
      state <= nxt;
      sw_meta <= Switches;
      sw_sync <= sw_meta;
      if (state == RD1) rd_latch <= is_io ? sw_sync : SRAM_DQ_in;
      if (state == RD2) data_q <= rd_latch;
      if (state == WR_PULSE && is_io) Hex_val <= MDR;
      if (state == ERR) Bus_err <= 1'b1;
      if (state != IDLE) seen <= 1'b1;
    end
  end
  // CE stays deasserted until the first access after reset and throughout a strobe conflict
  assign SRAM_CE_N   = (state == ERR || (state == IDLE && !seen)) ? 1'b1 : Mem_CE;
  assign SRAM_OE_N   = (state == RD1 || state == RD2) ? is_io : 1'b1;
  assign SRAM_WE_N   = (state == WR_PULSE) ? is_io : 1'b1;
  assign SRAM_DQ_oe  = state == WR_SETUP || state == WR_PULSE || state == WR_HOLD;
  assign SRAM_DQ_out = SRAM_DQ_oe ? MDR : '0;
  assign SRAM_ADDR   = ADDR_W'(MAR);
  assign SRAM_UB_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;
  assign Data_to_CPU = (state == RD2) ? rd_latch : data_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of SRAM pin sequencing, I/O decode, bus error and reset
module tb_mem_access_ctrl;
  logic Clk = 0, Reset = 1;
  logic [15:0] MAR = 0, MDR = 0, Switches = 0, SRAM_DQ_in;
  logic Mem_CE = 0, Mem_OE = 1, Mem_WE = 1;
  logic [19:0] SRAM_ADDR;
  logic SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_oe, Bus_err;
  logic [15:0] SRAM_DQ_out, Data_to_CPU, Hex_val;
  logic [15:0] mem [256];
  int n_cmp = 0, n_bad = 0;
  mem_access_ctrl dut (
    .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR(MDR), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE),
    .Mem_WE(Mem_WE), .Switches(Switches), .SRAM_DQ_in(SRAM_DQ_in), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
    .Data_to_CPU(Data_to_CPU), .Hex_val(Hex_val), .Bus_err(Bus_err)
  );
  always #5 Clk = ~Clk;
  assign SRAM_DQ_in = mem[SRAM_ADDR[7:0]];
  always @(posedge Clk) if (!SRAM_WE_N && !SRAM_CE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ_out;
  task automatic step(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #1;
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h42] = 16'hBEEF;
    step(2);
    Reset = 0;
    chk("rst_oe_n", SRAM_OE_N, 1);
    chk("rst_we_n", SRAM_WE_N, 1);
    chk("rst_ce_n", SRAM_CE_N, 1);
    chk("rst_dq_oe", SRAM_DQ_oe, 0);
    chk("rst_data", Data_to_CPU, 0);
    chk("rst_hex", Hex_val, 0);
    chk("rst_err", Bus_err, 0);
    chk("ub_lb", {SRAM_UB_N, SRAM_LB_N}, 0);
    MAR = 16'h0042; Mem_OE = 0;
    step;
    chk("rd1_oe_n", SRAM_OE_N, 0);
    chk("rd1_addr", SRAM_ADDR, 20'h00042);
    step;
    Mem_OE = 1;
    chk("rd2_oe_n", SRAM_OE_N, 0);
    chk("rd2_data", Data_to_CPU, 16'hBEEF);
    step;
    chk("rd_idle_oe_n", SRAM_OE_N, 1);
    chk("rd_hold_data", Data_to_CPU, 16'hBEEF);
    chk("idle_ce_n", SRAM_CE_N, 0);
    MAR = 16'h0010; MDR = 16'h1234; Mem_WE = 0;
    step;
    chk("wrs_we_n", SRAM_WE_N, 1);
    chk("wrs_dq_oe", SRAM_DQ_oe, 1);
    chk("wrs_dq_out", SRAM_DQ_out, 16'h1234);
    step;
    Mem_WE = 1;
    chk("wrp_we_n", SRAM_WE_N, 0);
    chk("wrp_oe_n", SRAM_OE_N, 1);
    chk("wrp_dq_oe", SRAM_DQ_oe, 1);
    step;
    chk("wrh_we_n", SRAM_WE_N, 1);
    chk("wrh_dq_oe", SRAM_DQ_oe, 1);
    step;
    chk("wr_idle_dq_oe", SRAM_DQ_oe, 0);
    chk("wr_idle_dq_out", SRAM_DQ_out, 0);
    chk("sram_10", mem[8'h10], 16'h1234);
    MAR = 16'h0042; Mem_OE = 0;
    step;
    Mem_OE = 1;
    step;
    chk("abort_data", Data_to_CPU, 16'hBEEF);
    chk("abort_oe_n", SRAM_OE_N, 1);
    MAR = 16'hFFFF; Switches = 16'h00A5;
    step(4);
    Mem_OE = 0;
    step;
    chk("io_rd1_oe_n", SRAM_OE_N, 1);
    step;
    Mem_OE = 1;
    chk("io_rd2_oe_n", SRAM_OE_N, 1);
    chk("io_rd2_data", Data_to_CPU, 16'h00A5);
    step;
    MDR = 16'h0C3F; Mem_WE = 0;
    step(2);
    Mem_WE = 1;
    chk("io_wrp_we_n", SRAM_WE_N, 1);
    chk("io_wrp_hex_old", Hex_val, 0);
    step;
    chk("io_hex", Hex_val, 16'h0C3F);
    step;
    Mem_OE = 0; Mem_WE = 0; MAR = 16'h0042;
    step;
    chk("err_oe_n", SRAM_OE_N, 1);
    chk("err_we_n", SRAM_WE_N, 1);
    chk("err_ce_n", SRAM_CE_N, 1);
    step;
    Mem_OE = 1; Mem_WE = 1;
    chk("err_flag", Bus_err, 1);
    step(3);
    chk("err_sticky", Bus_err, 1);
    chk("err_idle_ce_n", SRAM_CE_N, 0);
    MAR = 16'h0010; MDR = 16'h5555; Mem_WE = 0;
    step(2);
    chk("rstw_we_n", SRAM_WE_N, 0);
    Reset = 1; Mem_WE = 1;
    step;
    chk("rstw_we_n_hi", SRAM_WE_N, 1);
    chk("rstw_dq_oe", SRAM_DQ_oe, 0);
    chk("rstw_hex", Hex_val, 0);
    chk("rstw_err", Bus_err, 0);
    chk("rstw_data", Data_to_CPU, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
